// File: rtl/spi_fpga_slave_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_fpga_slave_sync
// Purpose  : SPI slave in which SCLK, CS and MOSI are oversampled in the system
//            clock domain. Optional macro SPI_FPGA_SLAVE_FRAME_ERROR_EN adds the
//            OUT_FRAME_ERROR abort strobe.
// Revision : 1.0 - initial release
// ============================================================================
module spi_fpga_slave_sync #(
  parameter int   PACK_LENGTH                = 8,
  parameter logic CPOL                       = 1'b0,
  parameter logic CPHA                       = 1'b1,
  parameter int   PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int   PACK_BIT_SEQUENCE_RECEIVE  = 1,
  parameter int   SYNC_STAGES                = 2
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET,
  input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
  input  logic                   IN_MOSI,
  input  logic                   IN_CS,
  input  logic                   IN_SCLK,
  output logic                   OUT_MISO,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
  output logic                   OUT_RECEIVE_VALID,
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
  output logic                   OUT_FRAME_ERROR,
`endif
  output logic                   OUT_BUSY
);

  localparam int CNT_W    = $clog2(PACK_LENGTH + 1);
  localparam int SETTLE   = SYNC_STAGES + 1;
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_now;
  logic                   cs_now;
  logic                   mosi_now;

  logic sclk_prev;
  logic cs_prev;
  logic mosi_d;
  logic lead_edge;
  logic trail_edge;
  logic cs_fall;
  logic cs_rise;
  logic sample_edge;
  logic shift_edge;

  logic [SETTLE_W-1:0] settle_cnt;
  logic                armed;

  state_t                 state;
  logic [PACK_LENGTH-1:0] tx_shift;
  logic [PACK_LENGTH-1:0] rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   skip_shift;
  logic                   last_sample;
  logic [PACK_LENGTH-1:0] rx_next;
  logic [PACK_LENGTH-1:0] tx_adv;
  logic                   tx_next_bit;
  logic                   tx_first_bit;
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
  logic                   frame_error;
`endif

  assign sclk_now = sclk_sync[SYNC_STAGES-1];
  assign cs_now   = cs_sync[SYNC_STAGES-1];
  assign mosi_now = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= {SYNC_STAGES{1'b1}};
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], IN_SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], IN_CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], IN_MOSI};
    end
  end

  // Edge pulses are registered; MOSI is delayed by the same stage so the
  // sampled bit stays aligned with the edge that samples it.
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      sclk_prev  <= CPOL;
      cs_prev    <= 1'b1;
      mosi_d     <= 1'b0;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      cs_fall    <= 1'b0;
      cs_rise    <= 1'b0;
    end else begin
      sclk_prev  <= sclk_now;
      cs_prev    <= cs_now;
      mosi_d     <= mosi_now;
      lead_edge  <= (sclk_now != sclk_prev) && (sclk_now != CPOL);
      trail_edge <= (sclk_now != sclk_prev) && (sclk_now == CPOL);
      cs_fall    <= cs_prev && !cs_now;
      cs_rise    <= !cs_prev && cs_now;
    end
  end

  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  // After reset the CS pin may still be low mid-frame; the forced-high
  // synchronizer would then fake a falling edge. Only arm once CS is seen high.
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else if (settle_cnt != SETTLE_W'(SETTLE)) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else if (cs_now && cs_prev) begin
      armed <= 1'b1;
    end
  end

  generate
    if (PACK_BIT_SEQUENCE_RECEIVE != 0) begin : g_rx_msb_first
      assign rx_next = {rx_shift[PACK_LENGTH-2:0], mosi_d};
    end else begin : g_rx_lsb_first
      assign rx_next = {mosi_d, rx_shift[PACK_LENGTH-1:1]};
    end

    if (PACK_BIT_SEQUENCE_TRANSMIT != 0) begin : g_tx_msb_first
      assign tx_first_bit = IN_TRANSMIT_DATA[PACK_LENGTH-1];
      assign tx_adv       = {tx_shift[PACK_LENGTH-2:0], 1'b0};
      assign tx_next_bit  = tx_shift[PACK_LENGTH-2];
    end else begin : g_tx_lsb_first
      assign tx_first_bit = IN_TRANSMIT_DATA[0];
      assign tx_adv       = {1'b0, tx_shift[PACK_LENGTH-1:1]};
      assign tx_next_bit  = tx_shift[1];
    end
  endgenerate

  assign last_sample = (bit_cnt == CNT_W'(PACK_LENGTH - 1));

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      state             <= IDLE;
      OUT_MISO          <= 1'b0;
      OUT_RECEIVE_DATA  <= '0;
      OUT_RECEIVE_VALID <= 1'b0;
      OUT_BUSY          <= 1'b0;
      tx_shift          <= '0;
      rx_shift          <= '0;
      bit_cnt           <= '0;
      skip_shift        <= 1'b0;
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
      frame_error       <= 1'b0;
`endif
    end else begin
      OUT_RECEIVE_VALID <= 1'b0;
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
      frame_error       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          OUT_MISO <= 1'b0;
          if (cs_fall && armed) begin
            state    <= LOAD;
            OUT_BUSY <= 1'b1;
          end
        end

        LOAD: begin
          tx_shift   <= IN_TRANSMIT_DATA;
          rx_shift   <= '0;
          bit_cnt    <= '0;
          skip_shift <= CPHA;
          if (cs_rise) begin
            state    <= IDLE;
            OUT_BUSY <= 1'b0;
            OUT_MISO <= 1'b0;
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
            frame_error <= 1'b1;
`endif
          end else begin
            state    <= SHIFT;
            OUT_MISO <= tx_first_bit;
          end
        end

        SHIFT: begin
          if (sample_edge && last_sample) begin
            // Completion wins over a simultaneous CS rise.
            rx_shift          <= rx_next;
            bit_cnt           <= bit_cnt + 1'b1;
            OUT_RECEIVE_DATA  <= rx_next;
            OUT_RECEIVE_VALID <= 1'b1;
            if (cs_rise) begin
              state    <= IDLE;
              OUT_BUSY <= 1'b0;
              OUT_MISO <= 1'b0;
            end else begin
              state <= WAIT_CS;
            end
          end else if (cs_rise) begin
            state    <= IDLE;
            OUT_BUSY <= 1'b0;
            OUT_MISO <= 1'b0;
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
            frame_error <= 1'b1;
`endif
          end else begin
            if (sample_edge) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + 1'b1;
            end
            if (shift_edge) begin
              if (skip_shift) begin
                skip_shift <= 1'b0;
              end else begin
                tx_shift <= tx_adv;
                OUT_MISO <= tx_next_bit;
              end
            end
          end
        end

        WAIT_CS: begin
          if (cs_rise) begin
            state    <= IDLE;
            OUT_BUSY <= 1'b0;
            OUT_MISO <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          OUT_BUSY <= 1'b0;
          OUT_MISO <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
  assign OUT_FRAME_ERROR = frame_error;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_fpga_slave_sync.sv
`default_nettype none
// Bench for spi_fpga_slave_sync: three slaves (default mode, CPOL=1/CPHA=0,
// LSB-first) driven by a behavioural SPI master at 16 system clocks per bit.
module tb_spi_fpga_slave_sync;

  localparam int SYNC = 2;
  localparam int HALF = 8;
  localparam int LAT  = SYNC + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sclk;
  logic [2:0] cs;
  logic [2:0] mosi;
  logic [2:0] miso;
  logic [2:0] valid;
  logic [2:0] busy;
  logic [7:0] txd [3];
  logic [7:0] rxd [3];
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
  logic [2:0] ferr;
  int         ecnt [3] = '{0, 0, 0};
`endif

  int         vcnt [3] = '{0, 0, 0};
  logic [7:0] last0 = 8'h00;
  logic [7:0] prev0 = 8'h00;
  int         checks = 0;
  int         fails  = 0;

  always #10 clk = ~clk;

  spi_fpga_slave_sync #(.SYNC_STAGES(SYNC)) u0 (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_TRANSMIT_DATA(txd[0]),
    .IN_MOSI(mosi[0]), .IN_CS(cs[0]), .IN_SCLK(sclk[0]),
    .OUT_MISO(miso[0]), .OUT_RECEIVE_DATA(rxd[0]), .OUT_RECEIVE_VALID(valid[0]),
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
    .OUT_FRAME_ERROR(ferr[0]),
`endif
    .OUT_BUSY(busy[0]));

  spi_fpga_slave_sync #(.CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(SYNC)) u1 (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_TRANSMIT_DATA(txd[1]),
    .IN_MOSI(mosi[1]), .IN_CS(cs[1]), .IN_SCLK(sclk[1]),
    .OUT_MISO(miso[1]), .OUT_RECEIVE_DATA(rxd[1]), .OUT_RECEIVE_VALID(valid[1]),
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
    .OUT_FRAME_ERROR(ferr[1]),
`endif
    .OUT_BUSY(busy[1]));

  spi_fpga_slave_sync #(.PACK_BIT_SEQUENCE_TRANSMIT(0), .PACK_BIT_SEQUENCE_RECEIVE(0),
                        .SYNC_STAGES(SYNC)) u2 (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_TRANSMIT_DATA(txd[2]),
    .IN_MOSI(mosi[2]), .IN_CS(cs[2]), .IN_SCLK(sclk[2]),
    .OUT_MISO(miso[2]), .OUT_RECEIVE_DATA(rxd[2]), .OUT_RECEIVE_VALID(valid[2]),
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
    .OUT_FRAME_ERROR(ferr[2]),
`endif
    .OUT_BUSY(busy[2]));

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (valid[d]) vcnt[d] <= vcnt[d] + 1;
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
      if (ferr[d]) ecnt[d] <= ecnt[d] + 1;
`endif
    end
    if (valid[0]) begin
      prev0 <= last0;
      last0 <= rxd[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic watch_valid(input int d, output int lat);
    lat = -1;
    for (int k = 1; k <= HALF; k++) begin
      cyc(1);
      if (valid[d] && lat < 0) lat = k;
    end
  endtask

  // One full master transfer; lat = clocks from final sample edge to VALID.
  task automatic xfer(input int d, input logic cpol, input logic cpha, input logic lsb,
                      input logic [7:0] mtx, input logic [7:0] stx, input int gap,
                      output logic [7:0] mrx, output int lat);
    int bi;
    mrx = 8'h00;
    lat = -1;
    txd[d] = stx;
    cs[d] = 1'b0;
    if (!cpha) mosi[d] = lsb ? mtx[0] : mtx[7];
    cyc(HALF);
    txd[d] = ~stx;
    for (int i = 0; i < 8; i++) begin
      bi = lsb ? i : 7 - i;
      if (!cpha) begin
        sclk[d] = ~cpol;
        mrx[bi] = miso[d];
        if (i == 7) watch_valid(d, lat);
        else cyc(HALF);
        sclk[d] = cpol;
        if (i < 7) mosi[d] = lsb ? mtx[i+1] : mtx[6-i];
        cyc(HALF);
      end else begin
        sclk[d] = ~cpol;
        mosi[d] = mtx[bi];
        cyc(HALF);
        sclk[d] = cpol;
        mrx[bi] = miso[d];
        if (i == 7) watch_valid(d, lat);
        else cyc(HALF);
      end
    end
    cs[d]   = 1'b1;
    mosi[d] = 1'b0;
    cyc(gap);
  endtask

  typedef struct {
    int         d;
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic [7:0] mtx;
    logic [7:0] stx;
    logic [7:0] exp_srx;
    logic [7:0] exp_mrx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] mrx;
    int         lat;
    int         v0;
    int         e0;

    vecs[0] = '{0, 1'b0, 1'b1, 1'b0, 8'hEA, 8'h53, 8'hEA, 8'h53};
    vecs[1] = '{0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h96, 8'h3C, 8'h96};
    vecs[3] = '{1, 1'b1, 1'b0, 1'b0, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[4] = '{1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hA5, 8'h0F};
    vecs[5] = '{2, 1'b0, 1'b1, 1'b1, 8'h01, 8'h80, 8'h01, 8'h80};
    vecs[6] = '{2, 1'b0, 1'b1, 1'b1, 8'h37, 8'hC8, 8'h37, 8'hC8};

    rst  = 1'b1;
    sclk = 3'b010;
    cs   = 3'b111;
    mosi = 3'b000;
    for (int d = 0; d < 3; d++) txd[d] = 8'h00;
    cyc(4);
    chk("reset_miso", {31'd0, miso[0]}, 0);
    chk("reset_rxdata", {24'd0, rxd[0]}, 0);
    chk("reset_valid", {29'd0, valid}, 0);
    chk("reset_busy", {29'd0, busy}, 0);
    rst = 1'b0;
    cyc(10);

    for (int i = 0; i < 7; i++) begin
      v0 = vcnt[vecs[i].d];
      xfer(vecs[i].d, vecs[i].cpol, vecs[i].cpha, vecs[i].lsb,
           vecs[i].mtx, vecs[i].stx, 12, mrx, lat);
      chk($sformatf("vec%0d_slave_rx", i), {24'd0, rxd[vecs[i].d]}, {24'd0, vecs[i].exp_srx});
      chk($sformatf("vec%0d_master_rx", i), {24'd0, mrx}, {24'd0, vecs[i].exp_mrx});
      chk($sformatf("vec%0d_valid_pulses", i), vcnt[vecs[i].d] - v0, 1);
      chk($sformatf("vec%0d_valid_latency", i), lat, LAT);
      chk($sformatf("vec%0d_busy_idle", i), {31'd0, busy[vecs[i].d]}, 0);
    end

    // Abort: 4 bits then CS high.
    v0 = vcnt[0];
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
    e0 = ecnt[0];
`else
    e0 = 0;
`endif
    cs[0] = 1'b0;
    cyc(HALF);
    chk("abort_busy_mid", {31'd0, busy[0]}, 1);
    for (int i = 0; i < 4; i++) begin
      sclk[0] = 1'b1;
      mosi[0] = i[0];
      cyc(HALF);
      sclk[0] = 1'b0;
      cyc(HALF);
    end
    cs[0] = 1'b1;
    cyc(12);
    chk("abort_no_valid", vcnt[0] - v0, 0);
    chk("abort_data_kept", {24'd0, rxd[0]}, {24'd0, 8'h3C});
    chk("abort_busy_idle", {31'd0, busy[0]}, 0);
    chk("abort_miso_idle", {31'd0, miso[0]}, 0);
`ifdef SPI_FPGA_SLAVE_FRAME_ERROR_EN
    chk("abort_frame_error", ecnt[0] - e0, 1);
`endif

    // Reset after bit 3, then finish the frame's clocks with CS still low.
    v0 = vcnt[0];
    txd[0] = 8'hFF;
    cs[0] = 1'b0;
    cyc(HALF);
    for (int i = 0; i < 3; i++) begin
      sclk[0] = 1'b1;
      mosi[0] = 1'b1;
      cyc(HALF);
      sclk[0] = 1'b0;
      cyc(HALF);
    end
    chk("midreset_busy_before", {31'd0, busy[0]}, 1);
    rst = 1'b1;
    cyc(3);
    chk("midreset_miso", {31'd0, miso[0]}, 0);
    chk("midreset_rxdata", {24'd0, rxd[0]}, 0);
    chk("midreset_valid", {31'd0, valid[0]}, 0);
    chk("midreset_busy", {31'd0, busy[0]}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk[0] = 1'b1;
      cyc(HALF);
      sclk[0] = 1'b0;
      cyc(HALF);
    end
    chk("midreset_ignored_valid", vcnt[0] - v0, 0);
    chk("midreset_ignored_busy", {31'd0, busy[0]}, 0);
    cs[0] = 1'b1;
    mosi[0] = 1'b0;
    cyc(HALF);

    v0 = vcnt[0];
    xfer(0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h11, SYNC + 1, mrx, lat);
    chk("b2b_first_master_rx", {24'd0, mrx}, {24'd0, 8'h11});
    xfer(0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h22, 12, mrx, lat);
    chk("b2b_second_master_rx", {24'd0, mrx}, {24'd0, 8'h22});
    chk("b2b_valid_pulses", vcnt[0] - v0, 2);
    chk("b2b_first_word", {24'd0, prev0}, {24'd0, 8'hA5});
    chk("b2b_second_word", {24'd0, last0}, {24'd0, 8'h3C});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
